// File: rtl/cpuf_pkg.sv
// ---------------------------------------------------------------------------
// cpuf_pkg : opcodes, sequencer state encoding and control-word layout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpuf_pkg;

  localparam logic [3:0] OP_LDA = 4'b1000;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1010;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_F_PC   = 4'd1,
    ST_F_MAR  = 4'd2,
    ST_F_WAIT = 4'd3,
    ST_F_IR   = 4'd4,
    ST_DECODE = 4'd5,
    ST_X_WAIT = 4'd6,
    ST_X_LD   = 4'd7,
    ST_X_ALU  = 4'd8,
    ST_X_JMP  = 4'd9,
    ST_RETIRE = 4'd10,
    ST_HALT   = 4'd11
  } state_e;

  typedef struct packed {
    logic pc_a;
    logic pc_ld;
    logic mar_a;
    logic ir_a;
    logic out_a;
    logic out_b;
    logic ad;
    logic sb;
  } ctrl_t;

  // Strobe set for a state; X_LD and X_ALU need the variant latched in DECODE.
  function automatic ctrl_t state_ctrl(state_e s, logic ld_b, logic alu_sub);
    ctrl_t c;
    c = '0;
    case (s)
      ST_F_PC:  c.pc_a  = 1'b1;
      ST_F_MAR: c.mar_a = 1'b1;
      ST_F_IR:  c.ir_a  = 1'b1;
      ST_X_JMP: c.pc_ld = 1'b1;
      ST_X_LD: begin
        c.out_a = ~ld_b;
        c.out_b = ld_b;
      end
      ST_X_ALU: begin
        c.ad = ~alu_sub;
        c.sb = alu_sub;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_wait_timer.sv
// ---------------------------------------------------------------------------
// cpu_wait_timer : RAM latency down-counter, done while on its last wait cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_wait_timer #(
  parameter int RAM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  generate
    if (RAM_LAT == 0) begin : g_no_wait
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset, load};
      assign done = 1'b1;
    end else begin : g_wait
      localparam int W = $clog2(RAM_LAT + 1);
      logic [W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (load) begin
          cnt_d = W'(RAM_LAT);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - W'(1);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign done = (cnt_q == W'(1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer : fetch/decode/execute microsequencer with registered strobes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_sequencer
  import cpuf_pkg::*;
#(
  parameter int RAM_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       ir_op,
  input  logic [3:0]       ir_addr,
  output logic             pc_a,
  output logic             pc_ld,
  output logic [3:0]       pc_ld_val,
  output logic             mar_a,
  output logic             ir_a,
  output logic             out_a,
  output logic             out_b,
  output logic             ad,
  output logic             sb,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam bit NO_WAIT = (RAM_LAT == 0);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             ld_b_q, ld_b_d;
  logic             alu_sub_q, alu_sub_d;
  logic [3:0]       pc_ld_val_q, pc_ld_val_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_load, wait_done;

  cpu_wait_timer #(.RAM_LAT(RAM_LAT)) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .load  (wait_load),
    .done  (wait_done)
  );

  always_comb begin
    state_d   = state_q;
    ld_b_d    = ld_b_q;
    alu_sub_d = alu_sub_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE:   if (run || step) state_d = ST_F_PC;
      ST_F_PC:   state_d = ST_F_MAR;
      ST_F_MAR:  state_d = NO_WAIT ? ST_F_IR : ST_F_WAIT;
      ST_F_WAIT: if (wait_done) state_d = ST_F_IR;
      ST_F_IR:   state_d = ST_DECODE;
      ST_DECODE: begin
        case (ir_op)
          OP_LDA, OP_LDB: begin
            ld_b_d  = (ir_op == OP_LDB);
            state_d = NO_WAIT ? ST_X_LD : ST_X_WAIT;
          end
          OP_ADD, OP_SUB: begin
            alu_sub_d = (ir_op == OP_SUB);
            state_d   = ST_X_ALU;
          end
          OP_JMP:  state_d = ST_X_JMP;
          OP_HLT:  state_d = ST_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_RETIRE;
          end
        endcase
      end
      ST_X_WAIT: if (wait_done) state_d = ST_X_LD;
      ST_X_LD, ST_X_ALU, ST_X_JMP: state_d = ST_RETIRE;
      ST_RETIRE: state_d = run ? ST_F_PC : ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are computed from the next state so they are valid while in it.
    if (state_d == ST_RETIRE) cnt_d = cnt_q + CNT_W'(1);
    ctrl_d      = state_ctrl(state_d, ld_b_d, alu_sub_d);
    pc_ld_val_d = (state_d == ST_X_JMP) ? ir_addr : 4'd0;
    busy_d      = !(state_d inside {ST_IDLE, ST_HALT});
    halted_d    = halted_q || (state_d == ST_HALT);
  end

  assign wait_load = ((state_d == ST_F_WAIT) && (state_q != ST_F_WAIT)) ||
                     ((state_d == ST_X_WAIT) && (state_q != ST_X_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      ld_b_q      <= 1'b0;
      alu_sub_q   <= 1'b0;
      pc_ld_val_q <= 4'd0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      ld_b_q      <= ld_b_d;
      alu_sub_q   <= alu_sub_d;
      pc_ld_val_q <= pc_ld_val_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc_a      = ctrl_q.pc_a;
  assign pc_ld     = ctrl_q.pc_ld;
  assign mar_a     = ctrl_q.mar_a;
  assign ir_a      = ctrl_q.ir_a;
  assign out_a     = ctrl_q.out_a;
  assign out_b     = ctrl_q.out_b;
  assign ad        = ctrl_q.ad;
  assign sb        = ctrl_q.sb;
  assign pc_ld_val = pc_ld_val_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule

`default_nettype wire
